// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: register-file size and pipe_ctrl FSM encodings.
package pipe_ctrl_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_FLUSH    = 2'd3
  } pipe_state_e;

  // One-hot register select; x0 is hardwired and never tracked.
  function automatic logic [REG_NUM-1:0] reg_onehot(input logic ena,
                                                    input logic [REG_AW-1:0] addr);
    logic [REG_NUM-1:0] v;
    v = '0;
    if (ena && (addr != '0)) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Register scoreboard: pending-writer and load-writer masks for RAW detection.
// PIPE_CTRL_FWD_EN: hazard mask is the load mask (only load-use stalls); otherwise the pending mask.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               rst,
  input  logic               i_set_ena,
  input  logic [REG_AW-1:0]  i_set_addr,
  input  logic               i_set_load,
  input  logic               i_clr_ena,
  input  logic [REG_AW-1:0]  i_clr_addr,
  output logic [REG_NUM-1:0] o_pending,
  output logic [REG_NUM-1:0] o_hazard_mask
);

  logic [REG_NUM-1:0] r_pending;
  logic [REG_NUM-1:0] r_load;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;

  always_comb begin
    w_set = reg_onehot(i_set_ena, i_set_addr);
    w_clr = reg_onehot(i_clr_ena, i_clr_addr);
  end

  // A same-cycle issue to the retiring register keeps the bit set.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_pending <= '0;
      r_load    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_load    <= (r_load & ~w_clr & ~w_set) | (i_set_load ? w_set : '0);
    end
  end

  assign o_pending = r_pending;

`ifdef PIPE_CTRL_FWD_EN
  assign o_hazard_mask = r_load;
`else
  assign o_hazard_mask = r_pending;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: RAW interlock, in-flight limit, memory stall, serialisation, flush.
// Hazard policy selected by PIPE_CTRL_FWD_EN inside pipe_scoreboard.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_rs1_r_ena,
  input  logic [4:0]  id_rs1_r_addr,
  input  logic        id_rs2_r_ena,
  input  logic [4:0]  id_rs2_r_addr,
  input  logic        id_rd_w_ena,
  input  logic [4:0]  id_rd_w_addr,
  input  logic        id_mem_to_reg,
  input  logic        id_serial,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        wb_valid,
  input  logic        wb_rd_w_ena,
  input  logic [4:0]  wb_rd_w_addr,
  output logic        id_issue,
  output logic        id_stall,
  output logic        id_flush,
  output logic        if_stall,
  output logic        pipe_stall,
  output logic [1:0]  state_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  pipe_state_e        r_state;
  pipe_state_e        w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [REG_NUM-1:0] w_pending;
  logic [REG_NUM-1:0] w_haz_mask;
  logic               w_mem_stall;
  logic               w_drained;
  logic               w_hazard;
  logic               w_flush;
  logic               w_issue;

  pipe_scoreboard u_sb (
    .clock         (clock),
    .rst           (rst),
    .i_set_ena     (id_issue & id_rd_w_ena),
    .i_set_addr    (id_rd_w_addr),
    .i_set_load    (id_mem_to_reg),
    .i_clr_ena     (wb_valid & wb_rd_w_ena),
    .i_clr_addr    (wb_rd_w_addr),
    .o_pending     (w_pending),
    .o_hazard_mask (w_haz_mask)
  );

  always_ff @(posedge clock) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state, issue decision and reset-gated outputs.
  always_comb begin
    w_state_nxt = r_state;
    id_issue    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    if_stall    = 1'b0;
    pipe_stall  = 1'b0;
    state_o     = 2'b00;

    w_mem_stall = mem_req & ~mem_ready;
    w_drained   = (r_count == '0) && (w_pending == '0);
    w_hazard    = (id_rs1_r_ena && (id_rs1_r_addr != '0) && w_haz_mask[id_rs1_r_addr]) ||
                  (id_rs2_r_ena && (id_rs2_r_addr != '0) && w_haz_mask[id_rs2_r_addr]);
    w_flush     = (ex_redirect & ~w_mem_stall) | (r_state == ST_FLUSH);
    w_issue     = id_valid & ~w_hazard & ~w_mem_stall & ~w_flush &
                  ((r_count < CNT_MAX) | wb_valid) & ~(id_serial & ~w_drained);

    if (w_mem_stall) begin
      w_state_nxt = ST_MEM_WAIT;
    end else if (ex_redirect) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      unique case (r_state)
        ST_RUN:   if (id_valid & id_serial & ~w_drained) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_drained) w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_RUN;
      endcase
    end

    if (!rst) begin
      id_issue   = w_issue;
      id_flush   = w_flush;
      pipe_stall = w_mem_stall;
      id_stall   = w_mem_stall | (id_valid & ~w_issue & ~w_flush);
      if_stall   = id_stall;
      state_o    = r_state;
    end
  end

  // In-flight counter; issue is already blocked at the limit unless a retire frees a slot.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_count <= '0;
    end else if (id_issue && !wb_valid) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!id_issue && wb_valid && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed table, corner-case sequences, randomized model comparison.
module tb_pipe_ctrl;

  localparam int MAXI = 3;

  logic       clock = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_r_ena, id_rs2_r_ena, id_rd_w_ena, id_mem_to_reg, id_serial;
  logic [4:0] id_rs1_r_addr, id_rs2_r_addr, id_rd_w_addr;
  logic       ex_redirect, mem_req, mem_ready, wb_valid, wb_rd_w_ena;
  logic [4:0] wb_rd_w_addr;
  logic       id_issue, id_stall, id_flush, if_stall, pipe_stall;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .rst(rst),
    .id_valid(id_valid),
    .id_rs1_r_ena(id_rs1_r_ena), .id_rs1_r_addr(id_rs1_r_addr),
    .id_rs2_r_ena(id_rs2_r_ena), .id_rs2_r_addr(id_rs2_r_addr),
    .id_rd_w_ena(id_rd_w_ena), .id_rd_w_addr(id_rd_w_addr),
    .id_mem_to_reg(id_mem_to_reg), .id_serial(id_serial),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_rd_w_ena(wb_rd_w_ena), .wb_rd_w_addr(wb_rd_w_addr),
    .id_issue(id_issue), .id_stall(id_stall), .id_flush(id_flush),
    .if_stall(if_stall), .pipe_stall(pipe_stall), .state_o(state_o)
  );

  typedef struct {
    logic       rst, id_valid, rs1_ena, rs2_ena, rd_ena, mem_to_reg, serial;
    logic [4:0] rs1, rs2, rd;
    logic       redirect, mem_req, mem_ready, wb_valid, wb_ena;
    logic [4:0] wb_rd;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [6:0] exp;
  } vec_t;

  // Output bundle order: {issue, id_stall, id_flush, if_stall, pipe_stall, state[1:0]}
  function automatic logic [6:0] E(logic iss, logic ids, logic fl, logic ifs, logic ps, logic [1:0] st);
    return {iss, ids, fl, ifs, ps, st};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t mk(logic r, logic v, logic ser, logic rdr, logic mrq, logic mrdy);
    stim_t s;
    s = idle();
    s.rst = r; s.id_valid = v; s.serial = ser; s.redirect = rdr;
    s.mem_req = mrq; s.mem_ready = mrdy;
    return s;
  endfunction

  function automatic stim_t wr(logic [4:0] rd, logic ld);
    stim_t s;
    s = idle();
    s.id_valid = 1'b1; s.rd_ena = 1'b1; s.rd = rd; s.mem_to_reg = ld;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; id_valid = s.id_valid;
    id_rs1_r_ena = s.rs1_ena; id_rs1_r_addr = s.rs1;
    id_rs2_r_ena = s.rs2_ena; id_rs2_r_addr = s.rs2;
    id_rd_w_ena = s.rd_ena; id_rd_w_addr = s.rd;
    id_mem_to_reg = s.mem_to_reg; id_serial = s.serial;
    ex_redirect = s.redirect; mem_req = s.mem_req; mem_ready = s.mem_ready;
    wb_valid = s.wb_valid; wb_rd_w_ena = s.wb_ena; wb_rd_w_addr = s.wb_rd;
  endtask

  function automatic logic [6:0] outs();
    return {id_issue, id_stall, id_flush, if_stall, pipe_stall, state_o};
  endfunction

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {iss,ids,fl,ifs,ps,st}=%b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle, compare mid-cycle, then advance past the edge.
  task automatic cyc(input string nm, input stim_t s, input logic [6:0] exp);
    drive(s);
    #3;
    check(nm, outs(), exp);
    tick();
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    tick();
    tick();
    drive(idle());
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pend, m_load;
  int          m_count, m_mode;

  function automatic logic [6:0] model_out(stim_t s);
    logic mst, haz, fl, drn, iss, ids;
    logic [31:0] hm;
    if (s.rst) return '0;
    mst = s.mem_req && !s.mem_ready;
`ifdef PIPE_CTRL_FWD_EN
    hm = m_load;
`else
    hm = m_pend;
`endif
    haz = (s.rs1_ena && (s.rs1 != '0) && hm[s.rs1]) || (s.rs2_ena && (s.rs2 != '0) && hm[s.rs2]);
    fl  = (s.redirect && !mst) || (m_mode == 3);
    drn = (m_count == 0) && (m_pend == '0);
    iss = s.id_valid && !haz && !mst && !fl && ((m_count < MAXI) || s.wb_valid) && !(s.serial && !drn);
    ids = mst || (s.id_valid && !iss && !fl);
    return {iss, ids, fl, ids, mst, 2'(m_mode)};
  endfunction

  task automatic model_update(input stim_t s, input logic [6:0] o);
    logic iss, mst, drn;
    int nm;
    if (s.rst) begin
      m_pend = '0; m_load = '0; m_count = 0; m_mode = 0;
      return;
    end
    iss = o[6];
    mst = o[2];
    drn = (m_count == 0) && (m_pend == '0);
    if (mst)                 nm = 1;
    else if (s.redirect)     nm = 3;
    else if (m_mode == 0)    nm = (s.id_valid && s.serial && !drn) ? 2 : 0;
    else if (m_mode == 2)    nm = drn ? 0 : 2;
    else                     nm = 0;
    m_mode  = nm;
    m_count = m_count + int'(iss) - ((s.wb_valid && m_count > 0) ? 1 : 0);
    if (s.wb_valid && s.wb_ena && (s.wb_rd != '0)) begin
      m_pend[s.wb_rd] = 1'b0;
      m_load[s.wb_rd] = 1'b0;
    end
    if (iss && s.rd_ena && (s.rd != '0)) begin
      m_pend[s.rd] = 1'b1;
      m_load[s.rd] = s.mem_to_reg;
    end
  endtask

`ifdef PIPE_CTRL_FWD_EN
  localparam logic [6:0] EXP_ALU_RAW = 7'b1000000;
`else
  localparam logic [6:0] EXP_ALU_RAW = 7'b0101000;
`endif
  localparam logic [6:0] ISS = 7'b1000000;
  localparam logic [6:0] STL = 7'b0101000;

  vec_t  tbl[8];
  stim_t s;
  logic [6:0] o;

  initial begin
    drive(idle());
    rst = 1'b1;

    // ---- directed table, each row from a clean reset state ----
    tbl[0] = '{mk(0,0,0,0,0,0), E(0,0,0,0,0,2'd0)};
    tbl[1] = '{mk(0,1,0,0,0,0), E(1,0,0,0,0,2'd0)};
    tbl[2] = '{mk(0,1,0,0,1,0), E(0,1,0,1,1,2'd0)};
    tbl[3] = '{mk(0,1,0,0,1,1), E(1,0,0,0,0,2'd0)};
    tbl[4] = '{mk(0,1,0,1,0,0), E(0,0,1,0,0,2'd0)};
    tbl[5] = '{mk(0,0,0,1,1,0), E(0,1,0,1,1,2'd0)};
    tbl[6] = '{mk(1,1,1,1,1,0), E(0,0,0,0,0,2'd0)};
    tbl[7] = '{mk(0,1,1,0,0,0), E(1,0,0,0,0,2'd0)};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(tbl[i].s);
      #3;
      check($sformatf("table_row%0d", i), outs(), tbl[i].exp);
    end

    // ---- ALU result then dependent read of x5 ----
    do_reset();
    cyc("alu_issue", wr(5'd5, 1'b0), ISS);
    s = idle(); s.id_valid = 1'b1; s.rs1_ena = 1'b1; s.rs1 = 5'd5;
    cyc("alu_raw_c1", s, EXP_ALU_RAW);
    s.wb_valid = 1'b1; s.wb_ena = 1'b1; s.wb_rd = 5'd5;
    cyc("alu_raw_wb", s, EXP_ALU_RAW);
    s.wb_valid = 1'b0; s.wb_ena = 1'b0;
    cyc("alu_raw_after_wb", s, ISS);

    // ---- load-use on x7 stalls in every configuration ----
    do_reset();
    cyc("load_issue", wr(5'd7, 1'b1), ISS);
    s = idle(); s.id_valid = 1'b1; s.rs2_ena = 1'b1; s.rs2 = 5'd7;
    cyc("load_use_c1", s, STL);
    cyc("load_use_c2", s, STL);
    s.wb_valid = 1'b1; s.wb_ena = 1'b1; s.wb_rd = 5'd7;
    cyc("load_use_wb", s, STL);
    s.wb_valid = 1'b0; s.wb_ena = 1'b0;
    cyc("load_use_after_wb", s, ISS);

    // ---- memory stall for three cycles ----
    do_reset();
    cyc("mem_wait_c1", mk(0,0,0,0,1,0), E(0,1,0,1,1,2'd0));
    cyc("mem_wait_c2", mk(0,0,0,0,1,0), E(0,1,0,1,1,2'd1));
    cyc("mem_wait_c3", mk(0,0,0,0,1,0), E(0,1,0,1,1,2'd1));
    cyc("mem_ready",   mk(0,0,0,0,1,1), E(0,0,0,0,0,2'd1));
    cyc("mem_back_run", mk(0,0,0,0,0,0), E(0,0,0,0,0,2'd0));

    // ---- redirect pulse flushes two cycles ----
    do_reset();
    cyc("flush_c1", mk(0,1,0,1,0,0), E(0,0,1,0,0,2'd0));
    cyc("flush_c2", mk(0,1,0,0,0,0), E(0,0,1,0,0,2'd3));
    cyc("flush_done", mk(0,1,0,0,0,0), ISS);

    // ---- fence with two writers in flight ----
    do_reset();
    cyc("fence_pre1", wr(5'd3, 1'b0), ISS);
    cyc("fence_pre2", wr(5'd4, 1'b0), ISS);
    s = mk(0,1,1,0,0,0);
    cyc("fence_wait_run", s, E(0,1,0,1,0,2'd0));
    cyc("fence_drain", s, E(0,1,0,1,0,2'd2));
    s.wb_valid = 1'b1; s.wb_ena = 1'b1; s.wb_rd = 5'd3;
    cyc("fence_wb3", s, E(0,1,0,1,0,2'd2));
    s.wb_rd = 5'd4;
    cyc("fence_wb4", s, E(0,1,0,1,0,2'd2));
    s.wb_valid = 1'b0; s.wb_ena = 1'b0;
    cyc("fence_issue", s, E(1,0,0,0,0,2'd2));
    cyc("fence_back_run", idle(), E(0,0,0,0,0,2'd0));

    // ---- in-flight limit ----
    do_reset();
    for (int i = 0; i < MAXI; i++) cyc($sformatf("limit_fill%0d", i), mk(0,1,0,0,0,0), ISS);
    cyc("limit_block", mk(0,1,0,0,0,0), STL);
    s = mk(0,1,0,0,0,0); s.wb_valid = 1'b1;
    cyc("limit_wb_frees", s, ISS);

    // ---- reset in the middle of a memory wait ----
    do_reset();
    cyc("rst_pre_issue", mk(0,1,0,0,0,0), ISS);
    cyc("rst_pre_mem1", mk(0,0,0,0,1,0), E(0,1,0,1,1,2'd0));
    cyc("rst_pre_mem2", mk(0,0,0,0,1,0), E(0,1,0,1,1,2'd1));
    cyc("rst_during_wait", mk(1,1,1,1,1,0), E(0,0,0,0,0,2'd0));
    drive(idle());
    #3;
    check("rst_after_state", outs(), E(0,0,0,0,0,2'd0));
    n_checks++;
    if (dut.r_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_after_count: got %0d expected 0", dut.r_count);
    end
    tick();

    // ---- randomized comparison against the reference model ----
    do_reset();
    m_pend = '0; m_load = '0; m_count = 0; m_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.rst        = ($urandom_range(0, 59) == 0);
      s.id_valid   = ($urandom_range(0, 3) != 0);
      s.rs1_ena    = 1'($urandom_range(0, 1));
      s.rs1        = 5'($urandom_range(0, 7));
      s.rs2_ena    = 1'($urandom_range(0, 1));
      s.rs2        = 5'($urandom_range(0, 7));
      s.rd_ena     = 1'($urandom_range(0, 1));
      s.rd         = 5'($urandom_range(0, 7));
      s.mem_to_reg = ($urandom_range(0, 2) == 0);
      s.serial     = ($urandom_range(0, 9) == 0);
      s.redirect   = ($urandom_range(0, 11) == 0);
      s.mem_req    = ($urandom_range(0, 4) == 0);
      s.mem_ready  = 1'($urandom_range(0, 1));
      s.wb_valid   = (m_count > 0) && ($urandom_range(0, 2) == 0);
      s.wb_ena     = ($urandom_range(0, 3) != 0);
      s.wb_rd      = 5'($urandom_range(0, 7));
      drive(s);
      #3;
      o = model_out(s);
      check($sformatf("random_cycle%0d", c), outs(), o);
      tick();
      model_update(s, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 3, maximum number of issued instructions not yet retired at WB.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port id_valid  in  1  ID holds a decoded instruction.
REQ-005 SHALL have ports id_rs1_r_ena/id_rs2_r_ena  in  1 each; id_rs1_r_addr/id_rs2_r_addr  in  5 each  source operand reads.
REQ-006 SHALL have ports id_rd_w_ena  in  1; id_rd_w_addr  in  5  destination write.
REQ-007 SHALL have port id_mem_to_reg  in  1  ID instruction is a load.
REQ-008 SHALL have port id_serial  in  1  ID instruction is fence/fence.i/system (must drain).
REQ-009 SHALL have port ex_redirect  in  1  EX resolved a taken branch/jump.
REQ-010 SHALL have ports mem_req  in  1; mem_ready  in  1  MEM-stage access handshake.
REQ-011 SHALL have ports wb_valid  in  1; wb_rd_w_ena  in  1; wb_rd_w_addr  in  5  retirement.
REQ-012 SHALL have ports id_issue, id_stall, id_flush, if_stall, pipe_stall  out  1 each.
REQ-013 SHALL have port state_o  out  2  current FSM state (debug).

Function
REQ-014 SHALL keep a 32-bit pending mask (bit r = in-flight writer of xr) and a 32-bit load mask (writer is a load); bit 0 never set.
REQ-015 SHALL keep an in-flight counter, range 0..MAX_INFLIGHT: +1 on id_issue, -1 on wb_valid, unchanged when both occur.
REQ-016 SHALL implement FSM states RUN=0, MEM_WAIT=1, DRAIN=2, FLUSH=3.
REQ-017 SHALL assert pipe_stall, if_stall and id_stall combinationally whenever mem_req & ~mem_ready; FSM enters MEM_WAIT and returns to RUN the cycle after mem_ready.
REQ-018 SHALL, when not memory-stalled and ex_redirect=1, assert id_flush, deassert id_issue, enter FLUSH; FLUSH asserts id_flush for exactly one cycle, then returns to RUN.
REQ-019 SHALL flag a RAW hazard when an enabled nonzero source hits the hazard mask (see Configuration).
REQ-020 SHALL assert id_issue = id_valid & ~hazard & ~pipe_stall & ~id_flush & (count<MAX_INFLIGHT | wb_valid) & ~(id_serial & ~drained).
REQ-021 SHALL define drained = count==0 & pending==0; id_valid & id_serial & ~drained enters DRAIN; DRAIN issues and returns to RUN on the first drained cycle; ex_redirect in DRAIN goes to FLUSH.
REQ-022 SHALL assert id_stall and if_stall whenever id_valid & ~id_issue & ~id_flush.
REQ-023 SHALL, on issue with id_rd_w_ena & rd!=0, set pending[rd] and set load[rd]=id_mem_to_reg.
REQ-024 SHALL, on wb_valid & wb_rd_w_ena & rd!=0, clear pending[rd] and load[rd]; a same-cycle issue to the same rd wins (bit stays set).
REQ-025 SHALL never let the counter wrap; issue at count==MAX_INFLIGHT without wb_valid is blocked.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, clear both masks, counter to 0, state RUN.
REQ-027 SHALL drive all outputs 0 combinationally while rst=1, regardless of other inputs (overrides mid-operation states).

Configuration
REQ-028 SHALL honour macro PIPE_CTRL_FWD_EN: defined, hazard mask = load mask (forwarding covers ALU results, only load-use stalls); undefined, hazard mask = pending mask (every RAW stalls until WB).

Structure
REQ-029 SHALL take FSM state encodings and REG_NUM=32 from the shared defines file included by all pipeline stages.
REQ-030 SHALL place mask set/clear logic in one sub-module pipe_scoreboard; FSM and counter stay in pipe_ctrl.

Verification
REQ-031 SHALL verify: issue addi x5 (rd=5), next ID reads x5 -> FWD_EN: id_issue=1; no FWD_EN: id_stall=1 until wb rd=5, issue the cycle after.
REQ-032 SHALL verify: load to x7, next ID reads x7 -> id_stall=1 in both configs until wb rd=7.
REQ-033 SHALL verify: mem_req=1, mem_ready=0 for 3 cycles -> pipe_stall=1 for 3 cycles, state_o=1, RUN the cycle after mem_ready.
REQ-034 SHALL verify: ex_redirect pulse -> id_flush=1 for 2 consecutive cycles, id_issue=0 both, state_o=3 on second.
REQ-035 SHALL verify: fence in ID with count=2 -> state_o=2, issue on the cycle count reaches 0 and pending=0.
REQ-036 SHALL verify: rst asserted during MEM_WAIT -> all outputs 0, state_o=0 and count=0 after the edge.
